// File: rtl/range_union_accum.sv
// range_union_accum: folds a first-sorted stream of inclusive ranges into a union size and range count.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
module range_union_accum #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int SUM_WIDTH = DATA_WIDTH + 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    pair_valid_in,
  input  logic [2*DATA_WIDTH-1:0] pair_in,
  output logic                    pair_ready_out,
  input  logic                    stream_done_in,
  input  logic                    clear_in,
  output logic [SUM_WIDTH-1:0]    total_out,
  output logic [DATA_WIDTH-1:0]   range_count_out,
  output logic                    done_out,
  output logic                    error_out
);
  localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [DATA_WIDTH-1:0] cur_lo, cur_hi, first, second, new_lo, new_hi;
  logic held, xfer, bad, good, overlap;
  logic [SUM_WIDTH-1:0] span;
  assign first = pair_in[2*DATA_WIDTH-1:DATA_WIDTH];
  assign second = pair_in[DATA_WIDTH-1:0];
  assign pair_ready_out = !state[1];
  assign done_out = state == DONE;
  assign xfer = pair_valid_in && pair_ready_out;
  assign bad = first > second;
  assign good = xfer && !bad;
  // Extra bit keeps cur_hi+1 from wrapping at all-ones; the lower test catches out-of-order pairs below cur_lo.
  assign overlap = held
    && ({1'b0, first} <= {1'b0, cur_hi} + (DATA_WIDTH+1)'(1))
    && ({1'b0, second} + (DATA_WIDTH+1)'(1) >= {1'b0, cur_lo});
  assign new_lo = first < cur_lo ? first : cur_lo;
  assign new_hi = second > cur_hi ? second : cur_hi;
  assign span = SUM_WIDTH'(cur_hi) - SUM_WIDTH'(cur_lo) + SUM_WIDTH'(1);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      held <= 1'b0;
      cur_lo <= '0;
      cur_hi <= '0;
      total_out <= '0;
      range_count_out <= '0;
      error_out <= 1'b0;
    end else begin
      case (state)
        IDLE, ACTIVE: begin
          if (xfer && bad) error_out <= 1'b1;
          if (good) begin
            held <= 1'b1;
            if (held && first < cur_lo) error_out <= 1'b1;
            if (overlap) begin
              cur_lo <= new_lo;
              cur_hi <= new_hi;
            end else begin
              if (held) begin
                total_out <= total_out + span;
                range_count_out <= range_count_out + DATA_WIDTH'(1);
              end
              cur_lo <= first;
              cur_hi <= second;
            end
          end
          state <= stream_done_in ? FLUSH : (good ? ACTIVE : state);
        end
        FLUSH: begin
          if (held) begin
            total_out <= total_out + span;
            range_count_out <= range_count_out + DATA_WIDTH'(1);
          end
          held <= 1'b0;
          state <= DONE;
        end
        default: begin
          if (clear_in) begin
            state <= IDLE;
            held <= 1'b0;
            cur_lo <= '0;
            cur_hi <= '0;
            total_out <= '0;
            range_count_out <= '0;
            error_out <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule
